// File: rtl/seq_div_if.sv
// Handshake and data bundle between the execute stage and the sequential divider.
interface seq_div_if;
    logic        start;
    logic [31:0] x;
    logic [15:0] y;
    logic        word_op;
    logic        signed_op;
    logic        busy;
    logic        done;
    logic        exc;
    logic [31:0] o;

    modport master (
        output start, x, y, word_op, signed_op,
        input  busy, done, exc, o
    );

    modport slave (
        input  start, x, y, word_op, signed_op,
        output busy, done, exc, o
    );
endinterface

// File: rtl/seq_div.sv
// Multi-cycle restoring divider for DIV/IDIV (word and byte modes).
// Works on operand magnitudes, producing one quotient bit per cycle, then fixes
// up the signs and checks the signed quotient range before reporting.
module seq_div #(
    parameter int WIDTH = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    seq_div_if.slave bus
);
    localparam int HALF  = WIDTH / 2;
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, DIV, FIX, FINISH} state_t;

    state_t state, next_state;

    logic [WIDTH-1:0]   rem_r;
    logic [WIDTH-1:0]   quo_r;
    logic [WIDTH-1:0]   divisor_r;
    logic [CNT_W-1:0]   cnt;
    logic               sign_q;
    logic               sign_r;
    logic               word_r;
    logic               signed_r;
    logic               exc_r;
    logic [2*WIDTH-1:0] o_r;

    logic               sx;
    logic               sy;
    logic [2*WIDTH-1:0] x_ext;
    logic [2*WIDTH-1:0] abs_x;
    logic [WIDTH-1:0]   y_ext;
    logic [WIDTH-1:0]   abs_y;
    logic [WIDTH-1:0]   hi_mag;
    logic [WIDTH-1:0]   lo_mag;
    logic               div_zero;
    logic               pre_ovf;

    logic [WIDTH:0]     shifted;
    logic               fits;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   rem_step;

    logic [WIDTH-1:0]   q_mag;
    logic [WIDTH-1:0]   q_fin;
    logic [WIDTH-1:0]   r_fin;
    logic [WIDTH-1:0]   limit;
    logic               range_err;
    logic [2*WIDTH-1:0] result;

    // Operand magnitudes and the early-exit checks, taken straight from the inputs.
    // The byte-mode low dividend half is left-aligned so the next bit always sits at the MSB.
    always_comb begin
        sx       = bus.signed_op & (bus.word_op ? bus.x[2*WIDTH-1] : bus.x[WIDTH-1]);
        sy       = bus.signed_op & (bus.word_op ? bus.y[WIDTH-1] : bus.y[HALF-1]);
        x_ext    = bus.word_op ? bus.x : {{WIDTH{sx}}, bus.x[WIDTH-1:0]};
        abs_x    = sx ? -x_ext : x_ext;
        hi_mag   = bus.word_op ? abs_x[2*WIDTH-1:WIDTH] : {{HALF{1'b0}}, abs_x[WIDTH-1:HALF]};
        lo_mag   = bus.word_op ? abs_x[WIDTH-1:0] : {abs_x[HALF-1:0], {HALF{1'b0}}};
        y_ext    = bus.word_op ? bus.y : {{HALF{sy}}, bus.y[HALF-1:0]};
        abs_y    = sy ? -y_ext : y_ext;
        div_zero = (abs_y == '0);
        pre_ovf  = (hi_mag >= abs_y);
    end

    // One restoring step: shift in the next dividend bit and subtract when it fits.
    always_comb begin
        shifted  = {rem_r, quo_r[WIDTH-1]};
        fits     = (shifted >= {1'b0, divisor_r});
        diff     = shifted[WIDTH-1:0] - divisor_r;
        rem_step = fits ? diff : shifted[WIDTH-1:0];
    end

    // Sign fix-up, signed range check and result packing.
    always_comb begin
        q_mag     = word_r ? quo_r : {{HALF{1'b0}}, quo_r[HALF-1:0]};
        q_fin     = sign_q ? -q_mag : q_mag;
        r_fin     = sign_r ? -rem_r : rem_r;
        limit     = word_r ? (WIDTH'(1) << (WIDTH - 1)) : (WIDTH'(1) << (HALF - 1));
        range_err = signed_r & (sign_q ? (q_mag > limit) : (q_mag >= limit));
        result    = word_r ? {r_fin, q_fin}
                           : {{WIDTH{1'b0}}, r_fin[HALF-1:0], q_fin[HALF-1:0]};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic and the status outputs decoded from the state.
    always_comb begin
        next_state = state;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) next_state = (div_zero || pre_ovf) ? FINISH : DIV;
            end
            DIV: begin
                bus.busy = 1'b1;
                if (cnt == '0) next_state = FIX;
            end
            FIX: begin
                bus.busy   = 1'b1;
                next_state = FINISH;
            end
            FINISH: begin
                bus.done   = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and result/exception registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_r     <= '0;
            quo_r     <= '0;
            divisor_r <= '0;
            cnt       <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            word_r    <= 1'b0;
            signed_r  <= 1'b0;
            exc_r     <= 1'b0;
            o_r       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        word_r    <= bus.word_op;
                        signed_r  <= bus.signed_op;
                        sign_q    <= sx ^ sy;
                        sign_r    <= sx;
                        divisor_r <= abs_y;
                        rem_r     <= hi_mag;
                        quo_r     <= lo_mag;
                        cnt       <= bus.word_op ? CNT_W'(WIDTH - 1) : CNT_W'(HALF - 1);
                        if (div_zero || pre_ovf) exc_r <= 1'b1;
                    end
                end
                DIV: begin
                    rem_r <= rem_step;
                    quo_r <= {quo_r[WIDTH-2:0], fits};
                    cnt   <= cnt - 1'b1;
                end
                FIX: begin
                    exc_r <= range_err;
                    if (!range_err) o_r <= result;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.exc = exc_r;
    assign bus.o   = o_r;

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: directed cases, start-ignore/abort, and
// randomized back-to-back operations checked against an arithmetic model.
module tb_seq_div;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    seq_div_if dif ();

    seq_div dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net in case the run stalls.
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Arithmetic reference: plain integer division on sign/zero-extended operands.
    function automatic void model(input logic [31:0] xi, input logic [15:0] yi,
                                  input logic wi, input logic si, input logic [31:0] prev_o,
                                  output logic e, output logic [31:0] ov, output int lat);
        int          w;
        longint      dd;
        longint      dv;
        longint      md;
        longint      mv;
        longint      q;
        longint      r;
        logic signed [31:0] xs32;
        logic signed [15:0] xs16;
        logic signed [15:0] ys16;
        logic signed [7:0]  ys8;
        w    = wi ? 16 : 8;
        xs32 = xi;
        xs16 = xi[15:0];
        ys16 = yi;
        ys8  = yi[7:0];
        if (wi) begin
            dd = si ? longint'(xs32) : longint'(xi);
            dv = si ? longint'(ys16) : longint'(yi);
        end else begin
            dd = si ? longint'(xs16) : longint'(xi[15:0]);
            dv = si ? longint'(ys8)  : longint'(yi[7:0]);
        end
        ov  = prev_o;
        e   = 1'b1;
        lat = 1;
        if (dv == 0) return;
        md = (dd < 0) ? -dd : dd;
        mv = (dv < 0) ? -dv : dv;
        if ((md >> w) >= mv) return;
        lat = w + 2;
        q   = dd / dv;
        r   = dd % dv;
        if (si && (q > (longint'(1) << (w - 1)) - 1 || q < -(longint'(1) << (w - 1)))) return;
        e  = 1'b0;
        ov = wi ? {r[15:0], q[15:0]} : {16'h0, r[7:0], q[7:0]};
    endfunction

    // Issues one start and waits (bounded) for done; returns what was observed.
    task automatic do_op(input logic [31:0] xi, input logic [15:0] yi, input logic wi,
                         input logic si, output int lat, output logic to,
                         output logic e, output logic [31:0] ov);
        @(posedge clk); #1;
        dif.x         = xi;
        dif.y         = yi;
        dif.word_op   = wi;
        dif.signed_op = si;
        dif.start     = 1'b1;
        @(posedge clk); #1;
        dif.start = 1'b0;
        lat       = 1;
        while (dif.done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        to = (dif.done !== 1'b1);
        e  = dif.exc;
        ov = dif.o;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        dif.start     = 1'b0;
        dif.x         = '0;
        dif.y         = '0;
        dif.word_op   = 1'b0;
        dif.signed_op = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (dif.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", dif.busy); end
        checks++; if (dif.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%b exp=0", dif.done); end
        checks++; if (dif.exc !== 1'b0) begin errors++; $display("[TB] FAIL reset_exc got=%b exp=0", dif.exc); end
        checks++; if (dif.o !== 32'h0) begin errors++; $display("[TB] FAIL reset_o got=%h exp=00000000", dif.o); end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] tx [6]   = '{32'h0001_0000, 32'h1234_5678, 32'h0002_0000,
                                  32'h0000_0080, 32'h0000_FF9C, 32'h0000_FF80};
        logic [15:0] ty [6]   = '{16'h0002, 16'h0000, 16'h0002, 16'h0001, 16'h0007, 16'h0001};
        logic        tw [6]   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        ts [6]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int          tlat [6] = '{18, 1, 1, 10, 10, 10};
        logic        texc [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] to_ [6]  = '{32'h0000_8000, 32'h0000_8000, 32'h0000_8000,
                                  32'h0000_8000, 32'h0000_FEF2, 32'h0000_0080};
        int          lat;
        logic        tmo;
        logic        e;
        logic [31:0] ov;
        for (int i = 0; i < 6; i++) begin
            do_op(tx[i], ty[i], tw[i], ts[i], lat, tmo, e, ov);
            checks++; if (tmo) begin errors++; $display("[TB] FAIL dir%0d_timeout got=no_done exp=done", i); end
            checks++; if (lat != tlat[i]) begin errors++; $display("[TB] FAIL dir%0d_latency got=%0d exp=%0d", i, lat, tlat[i]); end
            checks++; if (e !== texc[i]) begin errors++; $display("[TB] FAIL dir%0d_exc got=%b exp=%b", i, e, texc[i]); end
            checks++; if (ov !== to_[i]) begin errors++; $display("[TB] FAIL dir%0d_o got=%h exp=%h", i, ov, to_[i]); end
        end
    endtask

    task automatic test_ignore_and_abort();
        logic        ee;
        logic [31:0] eo;
        int          elat;
        int          cyc;
        int          done_seen;
        model(32'h0000_1234, 16'h0011, 1'b1, 1'b0, 32'h0000_0080, ee, eo, elat);
        @(posedge clk); #1;
        dif.x = 32'h0000_1234; dif.y = 16'h0011; dif.word_op = 1'b1; dif.signed_op = 1'b0;
        dif.start = 1'b1;
        @(posedge clk); #1;
        dif.start = 1'b0;
        cyc = 1;
        checks++; if (dif.busy !== 1'b1) begin errors++; $display("[TB] FAIL busy_after_start got=%b exp=1", dif.busy); end
        while (cyc < 5) begin @(posedge clk); #1; cyc++; end
        dif.x = 32'h0000_0005; dif.y = 16'h0001; dif.signed_op = 1'b1;
        dif.start = 1'b1;
        @(posedge clk); #1;
        dif.start = 1'b0;
        cyc++;
        while (dif.done !== 1'b1 && cyc < 40) begin @(posedge clk); #1; cyc++; end
        checks++; if (cyc != elat) begin errors++; $display("[TB] FAIL ignore_latency got=%0d exp=%0d", cyc, elat); end
        checks++; if (dif.busy !== 1'b0) begin errors++; $display("[TB] FAIL busy_at_done got=%b exp=0", dif.busy); end
        checks++; if (dif.o !== eo) begin errors++; $display("[TB] FAIL ignore_o got=%h exp=%h", dif.o, eo); end
        checks++; if (dif.exc !== ee) begin errors++; $display("[TB] FAIL ignore_exc got=%b exp=%b", dif.exc, ee); end
        @(posedge clk); #1;
        checks++; if (dif.done !== 1'b0) begin errors++; $display("[TB] FAIL done_single_pulse got=%b exp=0", dif.done); end

        dif.x = 32'h0000_7777; dif.y = 16'h0123; dif.word_op = 1'b1; dif.signed_op = 1'b0;
        dif.start = 1'b1;
        @(posedge clk); #1;
        dif.start = 1'b0;
        cyc = 1;
        while (cyc < 7) begin @(posedge clk); #1; cyc++; end
        rst_n = 1'b0;
        #1;
        checks++; if (dif.busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got=%b exp=0", dif.busy); end
        checks++; if (dif.done !== 1'b0) begin errors++; $display("[TB] FAIL abort_done got=%b exp=0", dif.done); end
        checks++; if (dif.o !== 32'h0) begin errors++; $display("[TB] FAIL abort_o got=%h exp=00000000", dif.o); end
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (dif.done === 1'b1) done_seen++;
        end
        checks++; if (done_seen != 0) begin errors++; $display("[TB] FAIL abort_no_done got=%0d exp=0", done_seen); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] xi;
        logic [15:0] yi;
        logic        wi;
        logic        si;
        logic        ee;
        logic [31:0] eo;
        int          elat;
        logic [31:0] prev_o;
        int          lat;
        logic        tmo;
        logic        e;
        logic [31:0] ov;
        prev_o = 32'h0;
        for (int i = 0; i < 1500; i++) begin
            wi = 1'($urandom);
            si = 1'($urandom);
            xi = $urandom;
            yi = 16'($urandom);
            case ($urandom % 4)
                0: ;
                1: xi = xi >> ($urandom % 32);
                2: begin
                    xi = xi >> ($urandom % 32);
                    if ($urandom % 2 == 0) xi = -xi;
                end
                default: yi = 16'($urandom % 4);
            endcase
            model(xi, yi, wi, si, prev_o, ee, eo, elat);
            do_op(xi, yi, wi, si, lat, tmo, e, ov);
            checks++; if (tmo) begin errors++; $display("[TB] FAIL rnd%0d_timeout got=no_done exp=done", i); end
            checks++; if (lat != elat) begin errors++; $display("[TB] FAIL rnd%0d_latency x=%h y=%h w=%b s=%b got=%0d exp=%0d", i, xi, yi, wi, si, lat, elat); end
            checks++; if (e !== ee) begin errors++; $display("[TB] FAIL rnd%0d_exc x=%h y=%h w=%b s=%b got=%b exp=%b", i, xi, yi, wi, si, e, ee); end
            checks++; if (ov !== eo) begin errors++; $display("[TB] FAIL rnd%0d_o x=%h y=%h w=%b s=%b got=%h exp=%h", i, xi, yi, wi, si, ov, eo); end
            prev_o = eo;
        end
    endtask

    // Test sequence.
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_ignore_and_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
